// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder sequencer: one shared 4-bit adder, LS nibble first, one nibble per cycle.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag (Ovf_out).
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [4*NIBBLES-1:0]   A_in,
    input  logic [4*NIBBLES-1:0]   B_in,
    input  logic                   Cin,
    output logic                   Busy,
    output logic                   Done,
    output logic [4*NIBBLES-1:0]   Sum_out,
    output logic                   Cout_out,
`ifdef SERIAL_ADD_OVF_EN
    output logic                   Ovf_out,
`endif
    output logic [3:0]             Add_A,
    output logic [3:0]             Add_B,
    output logic                   Add_Cin,
    input  logic [3:0]             Add_Sum,
    input  logic                   Add_Cout
);

    localparam int W   = 4 * NIBBLES;
    localparam int IW  = $clog2(NIBBLES) + 1;
    localparam int MSB = W - 1;

    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_carry;
    logic          r_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic          r_ovf;
`endif

    logic          w_run;
    logic          w_last;
    logic [3:0]    w_a;
    logic [3:0]    w_b;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_idx == LAST);

    // Select the active nibble of each latched operand
    always_comb begin
        w_a = 4'd0;
        w_b = 4'd0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) begin
                w_a = r_a[4*n +: 4];
                w_b = r_b[4*n +: 4];
            end
        end
    end

    assign Add_A    = w_run ? w_a : 4'd0;
    assign Add_B    = w_run ? w_b : 4'd0;
    assign Add_Cin  = w_run ? r_carry : 1'b0;

    assign Busy     = w_run;
    assign Done     = (r_state == S_DONE);
    assign Sum_out  = r_sum;
    assign Cout_out = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign Ovf_out  = r_ovf;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_a     <= A_in;
                        r_b     <= B_in;
                        r_carry <= Cin;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (r_idx == IW'(n)) begin
                            r_sum[4*n +: 4] <= Add_Sum;
                        end
                    end
                    r_carry <= Add_Cout;
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        r_cout  <= Add_Cout;
`ifdef SERIAL_ADD_OVF_EN
                        // Add_Sum[3] is the final sum MSB on the last nibble
                        r_ovf   <= (r_a[MSB] == r_b[MSB]) &&
                                   (Add_Sum[3] != r_a[MSB]);
`endif
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: vector table, hand sequences,
// and random operations checked against plain-arithmetic expectations.
module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic         Cin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum_out;
    logic         Cout_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         Ovf_out;
`endif
    logic [3:0]   Add_A;
    logic [3:0]   Add_B;
    logic         Add_Cin;
    logic [3:0]   Add_Sum;
    logic         Add_Cout;

    always #5 clk = ~clk;

    // External 4-bit adder
    assign {Add_Cout, Add_Sum} = {1'b0, Add_A} + {1'b0, Add_B} + {4'd0, Add_Cin};

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .Clk      (clk),
        .Reset    (rst),
        .Start    (Start),
        .A_in     (A_in),
        .B_in     (B_in),
        .Cin      (Cin),
        .Busy     (Busy),
        .Done     (Done),
        .Sum_out  (Sum_out),
        .Cout_out (Cout_out),
`ifdef SERIAL_ADD_OVF_EN
        .Ovf_out  (Ovf_out),
`endif
        .Add_A    (Add_A),
        .Add_B    (Add_B),
        .Add_Cin  (Add_Cin),
        .Add_Sum  (Add_Sum),
        .Add_Cout (Add_Cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    vec_t tbl[8];

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    logic [3:0] seq_a[$];
    logic [3:0] seq_b[$];
    logic       seq_c[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        seq_a.delete();
        seq_b.delete();
        seq_c.delete();
        @(negedge clk);
        A_in  = a;
        B_in  = b;
        Cin   = cin;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        A_in  = ~a;
        B_in  = W'($urandom);
        Cin   = ~cin;
        lat   = 0;
        while (!Done && lat < 40) begin
            if (Busy) begin
                seq_a.push_back(Add_A);
                seq_b.push_back(Add_B);
                seq_c.push_back(Add_Cin);
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [W-1:0] es, input logic ec,
                            input logic ev);
        logic [31:0] lo;
        logic [31:0] cin_k;
        logic [W-1:0] held;
        chk({tag, "/latency"}, lat, N);
        chk({tag, "/done"}, Done, 1);
        chk({tag, "/sum"}, Sum_out, es);
        chk({tag, "/cout"}, Cout_out, ec);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "/ovf"}, Ovf_out, ev);
`else
        if (ev === 1'bx) $display("%s: unexpected unknown flag", tag);
`endif
        chk({tag, "/busy_cycles"}, seq_a.size(), N);
        for (int k = 0; k < N && k < seq_a.size(); k++) begin
            lo    = 32'd1 << (4 * k);
            cin_k = ((32'(a) % lo) + (32'(b) % lo) + 32'(cin)) >> (4 * k);
            chk($sformatf("%s/add_a[%0d]", tag, k), seq_a[k], (a >> (4 * k)) & 4'hF);
            chk($sformatf("%s/add_b[%0d]", tag, k), seq_b[k], (b >> (4 * k)) & 4'hF);
            chk($sformatf("%s/add_cin[%0d]", tag, k), seq_c[k], cin_k);
        end
        held = Sum_out;
        @(posedge clk);
        #1;
        chk({tag, "/done_pulse"}, Done, 0);
        chk({tag, "/idle_busy"}, Busy, 0);
        chk({tag, "/held"}, Sum_out, es);
        chk({tag, "/idle_adder"}, {Add_A, Add_B, Add_Cin}, 0);
        if (held !== es) $display("%s: sum differs at done", tag);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        tbl[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst   = 1'b1;
        Start = 1'b0;
        A_in  = '0;
        B_in  = '0;
        Cin   = 1'b0;
        @(posedge clk);
        #1;
        chk("reset/busy", Busy, 0);
        chk("reset/done", Done, 0);
        chk("reset/sum", Sum_out, 0);
        chk("reset/cout", Cout_out, 0);
        chk("reset/adder", {Add_A, Add_B, Add_Cin}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle/busy", Busy, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin);
            check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                     tbl[i].s, tbl[i].c, tbl[i].v);
        end

        // Start held high through RUN/DONE with changing operands
        begin
            int dones;
            dones = 0;
            @(negedge clk);
            A_in  = 16'h0001;
            B_in  = 16'h0001;
            Cin   = 1'b0;
            Start = 1'b1;
            @(posedge clk);
            #1;
            A_in = 16'hAAAA;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (Done) begin
                    dones++;
                    Start = 1'b0;
                end
            end
            Start = 1'b0;
            chk("ignore/done_count", dones, 1);
            chk("ignore/sum", Sum_out, 16'h0002);
            chk("ignore/cout", Cout_out, 0);
        end

        // Reset in the second RUN cycle
        begin
            int dones;
            dones = 0;
            @(negedge clk);
            A_in  = 16'h8888;
            B_in  = 16'h8888;
            Cin   = 1'b0;
            Start = 1'b1;
            @(posedge clk);
            #1;
            Start = 1'b0;
            @(posedge clk);
            #1;
            chk("midrst/busy_before", Busy, 1);
            rst = 1'b1;
            #1;
            chk("midrst/busy", Busy, 0);
            chk("midrst/done", Done, 0);
            chk("midrst/sum", Sum_out, 0);
            chk("midrst/cout", Cout_out, 0);
            chk("midrst/adder", {Add_A, Add_B, Add_Cin}, 0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (Done) dones++;
            end
            chk("midrst/no_done", dones, 0);
            run_op(16'h0003, 16'h0004, 1'b0);
            check_op("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        end

        // Reset and Start in the same cycle
        @(negedge clk);
        rst   = 1'b1;
        Start = 1'b1;
        A_in  = 16'h1111;
        B_in  = 16'h2222;
        @(posedge clk);
        #1;
        chk("rst_start/busy", Busy, 0);
        @(negedge clk);
        Start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start/idle", Busy, 0);
        chk("rst_start/sum", Sum_out, 0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            logic [W:0]   full;
            logic         v;
            a    = W'($urandom);
            b    = W'($urandom);
            c    = 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
            run_op(a, b, c);
            check_op($sformatf("rnd%0d", i), a, b, c, full[W-1:0], full[W], v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs a wide (4*NIBBLES-bit) addition by time-multiplexing one external Adder_4bits instance, least-significant nibble first. It latches operands on Start, feeds the adder one nibble per cycle, and registers each nibble's Sum and its Cout as the carry for the next nibble. When finished it reports the wide sum and carry-out with a one-cycle Done pulse. It sits between a requesting datapath and the shared 4-bit adder.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (operand width = 4*NIBBLES); legal range 1..16

Ports:
Clk  in  1  system clock, rising-edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  request; sampled only in IDLE
A_in  in  4*NIBBLES  operand A, captured when Start is accepted
B_in  in  4*NIBBLES  operand B, captured when Start is accepted
Cin  in  1  carry-in, captured when Start is accepted
Busy  out  1  high while in RUN
Done  out  1  one-cycle pulse; result valid
Sum_out  out  4*NIBBLES  wide sum; held until the next accepted Start
Cout_out  out  1  final carry-out; held like Sum_out
Add_A  out  4  to adder A
Add_B  out  4  to adder B
Add_Cin  out  1  to adder Cin
Add_Sum  in  4  from adder Sum (combinational, same cycle)
Add_Cout  in  1  from adder Cout (combinational, same cycle)

Behaviour:
- Clock and reset: one clock, Clk; Reset is asynchronous and active-high.
- Reset values: state=IDLE, Busy=0, Done=0, Sum_out=0, Cout_out=0, nibble index=0, carry register=0, operand registers=0. Add_A, Add_B and Add_Cin are 0.
- FSM states:
  - IDLE: on a rising edge with Start=1, latch A_in, B_in and Cin (Cin goes into the carry register), clear Sum_out and Cout_out, set index=0, and go to RUN. If Start=0, stay in IDLE.
  - RUN: Add_A = A_reg[4k+3:4k], Add_B = B_reg[4k+3:4k], Add_Cin = carry register, where k = index.
    - Each edge: Sum_out[4k+3:4k] <= Add_Sum, carry register <= Add_Cout, index <= k+1.
    - On the edge with k = NIBBLES-1: Cout_out <= Add_Cout and go to DONE.
  - DONE: Done=1 for exactly one cycle, then go to IDLE on the next edge.
- Latency: if Start is sampled at edge E0, Done is high in the cycle after edge E(NIBBLES). With NIBBLES=4, Done is high 5 cycles after Start is sampled. Back-to-back throughput is one operation per NIBBLES+2 cycles.
- Outside RUN, Add_A=0, Add_B=0 and Add_Cin=0.
- Start is ignored in RUN and DONE: no re-latch and no queuing. The requester must re-assert Start in IDLE.
- Changes on A_in, B_in or Cin after acceptance have no effect on the operation in progress.
- Arithmetic is unsigned, modulo 2^(4*NIBBLES). Cout_out is bit 4*NIBBLES of A+B+Cin.
- Carry wrap: Add_Cout from nibble k is always the Add_Cin for nibble k+1. The carry register is never reset between nibbles.
- Index: width is ceil(log2(NIBBLES))+1 bits, so the compare is safe at NIBBLES=16. The index never exceeds NIBBLES-1 while in RUN.
- Reset mid-operation: immediate return to reset values, Done is not asserted, and the partial Sum_out is discarded (it reads 0).
- Reset in the same cycle as Start: Reset wins.

Optional Feature:
Macro SERIAL_ADD_OVF_EN.
- Defined: an extra output port Ovf_out (1 bit) is present.
  - Two's-complement overflow: Ovf_out = (A_reg[MSB]==B_reg[MSB]) && (final Sum_out[MSB]!=A_reg[MSB]).
  - Registered on the same edge as Cout_out.
  - Cleared on Reset and on Start acceptance; held with Sum_out.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- NIBBLES=4, A_in=16'h1234, B_in=16'h4321, Cin=0, Start pulse -> Busy high 4 cycles; Done high in cycle 5 after Start sampled; Sum_out=16'h5555, Cout_out=0. Add_A sequence: 4,3,2,1.
- A_in=16'hFFFF, B_in=16'h0001, Cin=0 -> Add_Cin sequence 0,1,1,1; Sum_out=16'h0000, Cout_out=1.
- A_in=16'hFFFF, B_in=16'h0000, Cin=1 -> Sum_out=16'h0000, Cout_out=1. Then A_in=16'h0000, B_in=16'h0000, Cin=0 -> Sum_out=16'h0000, Cout_out=0, so no carry leaks between operations.
- Start (A=16'h0001, B=16'h0001) accepted, then Start re-asserted with A=16'hAAAA during RUN -> ignored; Sum_out=16'h0002. Only one Done pulse.
- Reset asserted on the 2nd RUN cycle of 16'h8888+16'h8888 -> Busy=0, Done never pulses, Sum_out=0, Cout_out=0. A new Start of 16'h0003+16'h0004 then gives 16'h0007.
- With SERIAL_ADD_OVF_EN defined: 16'h7FFF+16'h0001, Cin=0 -> Sum_out=16'h8000, Ovf_out=1, Cout_out=0. Then 16'hFFFF+16'h0001 -> Ovf_out=0, Cout_out=1.
